// File: rtl/jk_register_bank_if.sv
// Signal bundle for jk_register_bank: control/data inputs and the register state with its change monitors.
interface jk_register_bank_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 en;
  logic                 sclr;
  logic                 load;
  logic [WIDTH-1:0]     d;
  logic [WIDTH-1:0]     j;
  logic [WIDTH-1:0]     k;
  logic                 cnt_clr;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     q_bar;
  logic [WIDTH-1:0]     rise;
  logic [WIDTH-1:0]     fall;
  logic                 changed;
  logic [CNT_WIDTH-1:0] change_cnt;

  modport master (
    output en, sclr, load, d, j, k, cnt_clr,
    input  q, q_bar, rise, fall, changed, change_cnt
  );

  modport slave (
    input  en, sclr, load, d, j, k, cnt_clr,
    output q, q_bar, rise, fall, changed, change_cnt
  );
endinterface

// File: rtl/jk_register_bank.sv
// Bank of independent JK flip-flops with shared enable/clear/load and registered
// per-bit rise/fall flags, an any-change flag and a saturating change counter.
module jk_register_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_WIDTH   = 16
) (
  input logic               clk,
  input logic               reset,
  jk_register_bank_if.slave bus
);

  // JK characteristic equation applied bitwise: Q+ = J & ~Q | ~K & Q
  function automatic logic [WIDTH-1:0] jk_next(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] jv,
    input logic [WIDTH-1:0] kv
  );
    return (jv & ~cur) | (~kv & cur);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0]     q_p1;
  logic [WIDTH-1:0]     rise_p1;
  logic [WIDTH-1:0]     fall_p1;
  logic                 changed_p1;
  logic [CNT_WIDTH-1:0] cnt_p1;

  logic [WIDTH-1:0]     q_next;
  logic [WIDTH-1:0]     rise_next;
  logic [WIDTH-1:0]     fall_next;
  logic                 changed_next;
  logic [CNT_WIDTH-1:0] cnt_next;

  // ---- stage p0: next-state selection and change detection ----
  always_comb begin
    q_next = q_p1;
    if (bus.sclr)
      q_next = RESET_VALUE;
    else if (bus.load)
      q_next = bus.d;
    else if (bus.en)
      q_next = jk_next(q_p1, bus.j, bus.k);

    rise_next    = q_next & ~q_p1;
    fall_next    = ~q_next & q_p1;
    changed_next = |(rise_next | fall_next);

    cnt_next = cnt_p1;
    if (bus.cnt_clr)
      cnt_next = '0;
    else if (changed_next)
      cnt_next = sat_inc(cnt_p1);
  end

  // ---- stage p1: state and monitor registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_p1       <= RESET_VALUE;
      rise_p1    <= '0;
      fall_p1    <= '0;
      changed_p1 <= 1'b0;
      cnt_p1     <= '0;
    end else begin
      q_p1       <= q_next;
      rise_p1    <= rise_next;
      fall_p1    <= fall_next;
      changed_p1 <= changed_next;
      cnt_p1     <= cnt_next;
    end
  end

  assign bus.q          = q_p1;
  assign bus.q_bar      = ~q_p1;
  assign bus.rise       = rise_p1;
  assign bus.fall       = fall_p1;
  assign bus.changed    = changed_p1;
  assign bus.change_cnt = cnt_p1;

endmodule

// File: tb/tb_jk_register_bank.sv
// Randomised and directed bench for jk_register_bank with a queue-based scoreboard.
module tb_jk_register_bank;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  jk_register_bank_if #(.WIDTH(W), .CNT_WIDTH(16)) bus_a ();
  jk_register_bank_if #(.WIDTH(W), .CNT_WIDTH(2))  bus_b ();

  jk_register_bank #(.WIDTH(W), .RESET_VALUE(RV), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  jk_register_bank #(.WIDTH(W), .RESET_VALUE(RV), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;
    int         cnt_a;
    int         cnt_b;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [7:0] mq;
  int mca, mcb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic l,
                       input logic [7:0] dd, input logic [7:0] jj, input logic [7:0] kk,
                       input logic cc);
    bus_a.en = e;  bus_a.sclr = s;  bus_a.load = l;  bus_a.d = dd;
    bus_a.j = jj;  bus_a.k = kk;    bus_a.cnt_clr = cc;
    bus_b.en = e;  bus_b.sclr = s;  bus_b.load = l;  bus_b.d = dd;
    bus_b.j = jj;  bus_b.k = kk;    bus_b.cnt_clr = cc;
  endtask

  // Reference: evaluate the rules on the inputs present before the edge, push after it.
  task automatic step();
    logic [7:0] qn;
    exp_t e;
    qn = mq;
    if (bus_a.sclr) qn = RV;
    else if (bus_a.load) qn = bus_a.d;
    else if (bus_a.en) begin
      for (int i = 0; i < W; i++) begin
        case ({bus_a.j[i], bus_a.k[i]})
          2'b01:   qn[i] = 1'b0;
          2'b10:   qn[i] = 1'b1;
          2'b11:   qn[i] = ~mq[i];
          default: qn[i] = mq[i];
        endcase
      end
    end
    e.q       = qn;
    e.rise    = qn & ~mq;
    e.fall    = ~qn & mq;
    e.changed = (qn != mq);
    if (bus_a.cnt_clr) begin
      mca = 0;
      mcb = 0;
    end else if (e.changed) begin
      mca = (mca < 65535) ? mca + 1 : mca;
      mcb = (mcb < 3) ? mcb + 1 : mcb;
    end
    e.cnt_a = mca;
    e.cnt_b = mcb;
    @(posedge clk);
    mq = qn;
    sb.push_back(e);
    #1;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    mq = RV; mca = 0; mcb = 0;
    chk("rst_q",       {24'b0, bus_a.q}, {24'b0, RV});
    chk("rst_q_bar",   {24'b0, bus_a.q_bar}, {24'b0, ~RV});
    chk("rst_rise",    {24'b0, bus_a.rise}, 32'h0);
    chk("rst_fall",    {24'b0, bus_a.fall}, 32'h0);
    chk("rst_changed", {31'b0, bus_a.changed}, 32'h0);
    chk("rst_cnt_a",   {16'b0, bus_a.change_cnt}, 32'h0);
    chk("rst_cnt_b",   {30'b0, bus_b.change_cnt}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // Monitor: every post-edge sample is one DUT output to compare.
  always @(negedge clk) begin
    if (!reset && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("q",       {24'b0, bus_a.q},        {24'b0, e.q});
      chk("q_bar",   {24'b0, bus_a.q_bar},    {24'b0, ~e.q});
      chk("rise",    {24'b0, bus_a.rise},     {24'b0, e.rise});
      chk("fall",    {24'b0, bus_a.fall},     {24'b0, e.fall});
      chk("changed", {31'b0, bus_a.changed},  {31'b0, e.changed});
      chk("cnt16",   {16'b0, bus_a.change_cnt}, e.cnt_a);
      chk("q_b",     {24'b0, bus_b.q},        {24'b0, e.q});
      chk("cnt2",    {30'b0, bus_b.change_cnt}, e.cnt_b);
    end
  end

  initial begin
    mq = RV; mca = 0; mcb = 0;
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    async_reset();

    drive(0, 0, 1, 8'h00, 8'h00, 8'h00, 0); step();
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 1); step();
    drive(1, 0, 0, 8'h00, 8'hF0, 8'h0F, 0); step(); step();
    drive(1, 0, 0, 8'h00, 8'hFF, 8'hFF, 0); repeat (3) step();
    drive(1, 1, 1, 8'h3C, 8'hFF, 8'h00, 0); step();
    drive(0, 0, 1, 8'h3C, 8'hFF, 8'h00, 0); step();
    drive(0, 0, 1, 8'h3C, 8'h00, 8'h00, 0); step();
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0); step(); step();
    drive(1, 0, 0, 8'h00, 8'hFF, 8'hFF, 1); step();
    drive(1, 0, 0, 8'h00, 8'hFF, 8'hFF, 0); repeat (5) step();
    drive(1, 0, 0, 8'h00, 8'hFF, 8'hFF, 1); step();
    drive(0, 0, 0, 8'h00, 8'hFF, 8'h00, 0); step(); step();
    drive(1, 0, 0, 8'h00, 8'hFF, 8'hFF, 0); repeat (3) step();
    drive(0, 0, 0, 8'h00, 8'hFF, 8'hFF, 0);
    async_reset();
    step();

    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 10) == 0,
            8'($urandom), 8'($urandom), 8'($urandom), ($urandom % 20) == 0);
      if (i == 150) async_reset();
      step();
    end

    for (int n = 0; n < 5 && sb.size() > 0; n++) @(negedge clk);
    #1;
    chk("scoreboard_drain", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jk_register_bank.md
Name: jk_register_bank

Overview:
- WIDTH-bit bank of independent JK flip-flops.
- Each bit has its own J/K pair; the bank has shared enable, synchronous clear and parallel load.
- Registered change detection: per-bit rise/fall flags, an any-change pulse and a saturating change-event counter.
- Successor to the single-bit JK flop; used wherever sequential logic needs a multi-bit set/reset/toggle status register with activity monitoring.

Parameters:
- WIDTH, 8, number of JK bits in the bank (>=1).
- RESET_VALUE, {WIDTH{1'b0}}, value q takes on reset and on sclr.
- CNT_WIDTH, 16, width of the change-event counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  enables JK update; when 0, q holds unless sclr or load is asserted.
- sclr  input  1  synchronous clear of q to RESET_VALUE.
- load  input  1  synchronous parallel load of d into q.
- d  input  WIDTH  parallel load data.
- j  input  WIDTH  per-bit J.
- k  input  WIDTH  per-bit K.
- cnt_clr  input  1  synchronous clear of change_cnt.
- q  output  WIDTH  register state.
- q_bar  output  WIDTH  bitwise ~q, combinational.
- rise  output  WIDTH  per-bit 0->1 flag for the last edge, registered.
- fall  output  WIDTH  per-bit 1->0 flag for the last edge, registered.
- changed  output  1  OR of rise|fall, registered.
- change_cnt  output  CNT_WIDTH  saturating count of edges at which q changed.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk):
  - q = RESET_VALUE.
  - rise = 0, fall = 0, changed = 0, change_cnt = 0.
  - q_bar = ~RESET_VALUE.
- Next-state priority per rising edge, highest first:
  - sclr: q_next = RESET_VALUE.
  - load: q_next = d.
  - en: per bit i, {j[i],k[i]} = 00 hold; 01 clear to 0; 10 set to 1; 11 toggle (~q[i]).
  - otherwise: hold.
  - X/Z on j or k is not supported; the default case holds.
- Edge detection: computed from q_next vs current q and registered at the same edge as q.
  - rise = q_next & ~q; fall = ~q_next & q; changed = |(rise|fall).
  - The flags are valid in the same cycle that q shows the new value and last exactly one cycle unless q changes again.
  - If sclr or load leaves q unchanged, the flags are 0.
- change_cnt:
  - Increments by 1 at every edge where q_next != q.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - cnt_clr sets it to 0 and has priority over a simultaneous increment, so the result is 0.
  - cnt_clr does not affect q or the flags.
- Latency: one cycle from input to q and to the flags; q_bar follows q with no added cycle.
- Reset asserted mid-operation: everything returns to reset values at once. On the first edge after reset deasserts, normal priority applies; there is no spurious flag.
- sclr, load and en asserted together: sclr wins. load with en: load wins and j/k are ignored.

Test Plan:
- WIDTH=8, RESET_VALUE=8'hA5. Assert reset asynchronously between edges -> q=8'hA5 immediately, q_bar=8'h5A, change_cnt=0, rise=fall=0, changed=0.
- From q=8'h00, en=1, j=8'hF0, k=8'h0F -> next cycle q=8'hF0, rise=8'hF0, fall=0, changed=1, change_cnt=1. Hold the inputs one more cycle -> q unchanged, rise=0, changed=0, change_cnt=1.
- From q=8'hF0, en=1, j=k=8'hFF for 3 cycles -> q=8'h0F, 8'hF0, 8'h0F. fall/rise alternate between 8'hF0 and 8'h0F. change_cnt increases by 3.
- Priority check: sclr=1, load=1, d=8'h3C, en=1, j=8'hFF -> q=RESET_VALUE. Next cycle, sclr=0, load=1 -> q=8'h3C.
- CNT_WIDTH=2: force 5 changing edges -> change_cnt saturates at 3. Then cnt_clr=1 with a simultaneous change -> change_cnt=0, changed=1.
- en=0 with j=8'hFF, k=0 -> q holds and changed=0. Assert reset during a toggle sequence -> immediate return to 8'hA5, and the first post-reset edge with en=0 gives changed=0.
